pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (pc_reg -> ifetch -> if_id -> id -> id_ex -> ex -> regs).
- Generates PC redirect, per-stage hold (stall) and flush (bubble) controls.
- Inputs it resolves: taken jumps/branches from ex, load-use hazards between id and ex, multi-cycle ex operations, and an external halt request.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- XLEN, 32, address/data width.
- FLUSH_CYC, 2, total cycles flush_if_id stays asserted after a taken jump (>=1); covers ROM fetch latency.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- jump_en_i  in  1  ex resolved a taken jump/branch this cycle.
- jump_addr_i  in  XLEN  jump target.
- mc_start_i  in  1  ex starts a multi-cycle op this cycle.
- mc_done_i  in  1  multi-cycle op result valid this cycle.
- id_rs1_addr  in  5  rs1 of instruction in id.
- id_rs2_addr  in  5  rs2 of instruction in id.
- id_rs1_used  in  1  id instruction reads rs1.
- id_rs2_used  in  1  id instruction reads rs2.
- ex_rd_addr  in  5  rd of instruction in ex.
- ex_is_load  in  1  instruction in ex is a load.
- halt_req_i  in  1  external halt request.
- pc_load  out  1  pc_reg loads pc_load_addr next edge.
- pc_load_addr  out  XLEN  redirect target.
- hold_pc  out  1  pc_reg keeps value.
- hold_if_id  out  1  if_id keeps contents.
- hold_id_ex  out  1  id_ex keeps contents.
- flush_if_id  out  1  if_id loads NOP (0x00000013) next edge.
- flush_id_ex  out  1  id_ex loads NOP, rd_wen=0 next edge.
- stall_cnt  out  CNT_W  saturating count of cycles with hold_pc=1.

Behaviour:
- Reset: rst=0 forces state RUN, flush counter 0, stall_cnt 0. All control outputs are 0 and pc_load_addr is 0 while rst=0. Reset mid-stall or mid-flush abandons the operation immediately.
- FSM states: RUN, FLUSH, MC_WAIT, HALT. Outputs are a combinational function of state and inputs; state, counters and stall_cnt are registered.
- Load-use hazard (lu), combinational: ex_is_load and ex_rd_addr!=0 and ((id_rs1_used and id_rs1_addr==ex_rd_addr) or (id_rs2_used and id_rs2_addr==ex_rd_addr)).
- RUN, priority order:
  - 1) jump_en_i: pc_load=1, pc_load_addr=jump_addr_i, flush_if_id=1, flush_id_ex=1, no holds. If FLUSH_CYC>1, next state FLUSH with counter=FLUSH_CYC-1; else stay RUN.
  - 2) mc_start_i and not mc_done_i: hold_pc, hold_if_id, hold_id_ex =1; next state MC_WAIT.
  - 3) mc_start_i and mc_done_i: single-cycle op, no action.
  - 4) lu: hold_pc=1, hold_if_id=1, flush_id_ex=1 (one bubble); stay RUN. Next cycle the load has left ex, so lu clears naturally.
  - 5) halt_req_i: all three holds =1; next state HALT.
  - Otherwise all outputs 0.
- FLUSH:
  - flush_if_id=1 each cycle; counter decrements; returns to RUN on the cycle the counter reads 1.
  - A new jump_en_i in FLUSH restarts the sequence: pc_load with the new target, counter reloaded to FLUSH_CYC-1.
  - mc_start_i, lu and halt_req_i are ignored; their sources are bubbles.
- MC_WAIT:
  - While mc_done_i=0, all three holds =1.
  - In the cycle mc_done_i=1, holds =0 and next state is RUN.
  - jump_en_i is ignored in this state (ex is busy).
- HALT:
  - All holds =1 while halt_req_i=1.
  - When halt_req_i drops, holds =0 that cycle and next state is RUN.
  - halt_req_i asserted during FLUSH or MC_WAIT is honoured only after returning to RUN.
- hold_* and flush_* on the same register: flush wins, as the pipeline registers implement it.
- stall_cnt increments on every rising edge where hold_pc=1. It saturates at 2^CNT_W-1 and never wraps.

Decomposition:
- Shared header pipe_ctrl_defs.vh holds:
  - state encodings (RUN=2'd0, FLUSH=2'd1, MC_WAIT=2'd2, HALT=2'd3);
  - NOP constant 32'h00000013;
  - XLEN default.
- One sub-module, hazard_unit: purely combinational lu compare, reusable for later forwarding logic.

Test Plan:
- Reset: assert rst=0 with jump_en_i=1 -> all outputs 0, stall_cnt=0; release -> state RUN.
- Jump: jump_en_i=1, jump_addr_i=0x0000_0100 in RUN -> same cycle pc_load=1, pc_load_addr=0x100, flush_if_id=flush_id_ex=1; next cycle flush_if_id=1 only; following cycle all 0.
- Load-use: ex_is_load=1, ex_rd_addr=5, id_rs2_addr=5, id_rs2_used=1 -> one cycle of hold_pc=hold_if_id=flush_id_ex=1, stall_cnt +1. Repeat with ex_rd_addr=0 -> no stall.
- Multi-cycle: mc_start_i=1, mc_done_i rises 4 cycles later -> holds asserted 4 cycles, deasserted on the done cycle, stall_cnt=4. jump_en_i pulsed mid-wait is ignored.
- Priority: jump_en_i, mc_start_i, lu and halt_req_i all set in one RUN cycle -> only the jump actions occur; next state FLUSH.
- Saturation and halt: CNT_W=4, halt_req_i held 20 cycles -> stall_cnt stops at 15. Drop halt_req_i -> holds clear that cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding, NOP word, default width.
package pipe_ctrl_pkg;

  localparam int unsigned XlenDefault = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlush  = 2'd1,
    StMcWait = 2'd2,
    StHalt   = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Load-use hazard detect between the instruction in id and a load sitting in ex.
module hazard_unit (
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_is_load_i,
  output logic       lu_o
);

  logic rs1_hit, rs2_hit;

  // x0 is never a real dependency, so a load targeting it never stalls
  always_comb begin
    rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
    lu_o    = ex_is_load_i && (ex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: PC redirect, per-stage hold/flush and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = XlenDefault,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [XLEN-1:0]  jump_addr_i,
  input  logic             mc_start_i,
  input  logic             mc_done_i,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_is_load,
  input  logic             halt_req_i,
  output logic             pc_load,
  output logic [XLEN-1:0]  pc_load_addr,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned FcW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FcW-1:0] FlushLoad = FcW'(FLUSH_CYC - 1);

  state_e           state_q, state_d;
  logic [FcW-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             lu;

  hazard_unit u_hazard (
    .id_rs1_addr_i (id_rs1_addr),
    .id_rs2_addr_i (id_rs2_addr),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_used_i (id_rs2_used),
    .ex_rd_addr_i  (ex_rd_addr),
    .ex_is_load_i  (ex_is_load),
    .lu_o          (lu)
  );

  // Next state and control outputs; outputs are forced quiet while reset is held
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pc_load      = 1'b0;
    pc_load_addr = '0;
    hold_pc      = 1'b0;
    hold_if_id   = 1'b0;
    hold_id_ex   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (jump_en_i) begin
          pc_load      = 1'b1;
          pc_load_addr = jump_addr_i;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = StFlush;
            fcnt_d  = FlushLoad;
          end
        end else if (mc_start_i && !mc_done_i) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          state_d    = StMcWait;
        end else if (mc_start_i && mc_done_i) begin
          // single-cycle op: nothing to do
        end else if (lu) begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
        end else if (halt_req_i) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          state_d    = StHalt;
        end
      end
      StFlush: begin
        flush_if_id = 1'b1;
        if (jump_en_i) begin
          // a new redirect restarts the flush window
          pc_load      = 1'b1;
          pc_load_addr = jump_addr_i;
          flush_id_ex  = 1'b1;
          fcnt_d       = FlushLoad;
        end else if (fcnt_q <= FcW'(1)) begin
          state_d = StRun;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FcW'(1);
        end
      end
      StMcWait: begin
        if (mc_done_i) begin
          state_d = StRun;
        end else begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
        end
      end
      StHalt: begin
        if (halt_req_i) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if (!rst) begin
      pc_load      = 1'b0;
      pc_load_addr = '0;
      hold_pc      = 1'b0;
      hold_if_id   = 1'b0;
      hold_id_ex   = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
    end
  end

  // Saturating count of held-PC cycles
  always_comb begin
    stall_d = stall_q;
    if (hold_pc && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State, flush counter and stall counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      fcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for RUN-state behaviour plus hand sequences.
module tb_pipe_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             jump_en_i = 1'b0;
  logic [XLEN-1:0]  jump_addr_i = '0;
  logic             mc_start_i = 1'b0, mc_done_i = 1'b0;
  logic [4:0]       id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic             id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_is_load = 1'b0;
  logic             halt_req_i = 1'b0;
  logic             pc_load, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
  logic [XLEN-1:0]  pc_load_addr;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl #(.XLEN(XLEN), .FLUSH_CYC(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .mc_start_i   (mc_start_i),
    .mc_done_i    (mc_done_i),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd_addr   (ex_rd_addr),
    .ex_is_load   (ex_is_load),
    .halt_req_i   (halt_req_i),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .hold_pc      (hold_pc),
    .hold_if_id   (hold_if_id),
    .hold_id_ex   (hold_id_ex),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jmp;
    logic [31:0] jaddr;
    logic        mcs, mcd;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        ld, halt;
    logic [5:0]  ctl;    // {pc_load, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
    logic [31:0] paddr;
    logic [3:0]  cnt;
  } vec_t;

  function automatic vec_t mk(logic jmp, logic [31:0] jaddr, logic mcs, logic mcd,
                              logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic ld, logic halt, logic [5:0] ctl,
                              logic [31:0] paddr, logic [3:0] cnt);
    vec_t v;
    v.jmp = jmp; v.jaddr = jaddr; v.mcs = mcs; v.mcd = mcd;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.ld = ld; v.halt = halt;
    v.ctl = ctl; v.paddr = paddr; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {pc_load, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    jump_en_i = 0; jump_addr_i = '0; mc_start_i = 0; mc_done_i = 0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd_addr = '0; ex_is_load = 0; halt_req_i = 0;
  endtask

  task automatic apply(vec_t v);
    jump_en_i = v.jmp; jump_addr_i = v.jaddr; mc_start_i = v.mcs; mc_done_i = v.mcd;
    id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_rd_addr = v.rd; ex_is_load = v.ld; halt_req_i = v.halt;
  endtask

  // Called at posedge+1; leaves at the next posedge+1
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    idle();
    next_cycle();
    rst = 1;
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h0,   4'd0);
    tbl[1]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100011, 32'h100, 4'd0);
    tbl[2]  = mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 32'h0,   4'd0);
    tbl[3]  = mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h0,   4'd0);
    tbl[4]  = mk(0, 32'h0,   0, 0, 0, 5, 0, 1, 5, 1, 0, 6'b011001, 32'h0,   4'd0);
    tbl[5]  = mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h0,   4'd1);
    tbl[6]  = mk(0, 32'h0,   0, 0, 0, 0, 0, 1, 0, 1, 0, 6'b000000, 32'h0,   4'd1);
    tbl[7]  = mk(0, 32'h0,   0, 0, 7, 0, 1, 0, 7, 1, 0, 6'b011001, 32'h0,   4'd1);
    tbl[8]  = mk(0, 32'h0,   0, 0, 7, 0, 0, 0, 7, 1, 0, 6'b000000, 32'h0,   4'd2);
    tbl[9]  = mk(0, 32'h0,   0, 0, 7, 0, 1, 0, 7, 0, 0, 6'b000000, 32'h0,   4'd2);
    tbl[10] = mk(0, 32'h0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h0,   4'd2);
    tbl[11] = mk(1, 32'h200, 1, 0, 3, 0, 1, 0, 3, 1, 1, 6'b100011, 32'h200, 4'd2);
    tbl[12] = mk(0, 32'h0,   1, 0, 3, 0, 1, 0, 3, 1, 1, 6'b000010, 32'h0,   4'd2);
    tbl[13] = mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b011100, 32'h0,   4'd2);
    tbl[14] = mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b011100, 32'h0,   4'd3);
    tbl[15] = mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h0,   4'd4);
    tbl[16] = mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h0,   4'd4);

    // Reset with a jump pending: everything quiet
    idle();
    #1;
    jump_en_i = 1; jump_addr_i = 32'h0000_0444;
    #2;
    chk("rst_ctl", 32'(ctl_now()), 32'h0);
    chk("rst_addr", pc_load_addr, 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    next_cycle();
    chk("rst_ctl_held", 32'(ctl_now()), 32'h0);
    idle();
    rst = 1;

    // Vector table from RUN
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #3;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d_addr", i), pc_load_addr, tbl[i].paddr);
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
      next_cycle();
    end

    // Multi-cycle op: done arrives 4 cycles after start, jump mid-wait ignored
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      mc_start_i = (c == 0);
      mc_done_i  = (c == 4);
      if (c == 2) begin
        jump_en_i = 1; jump_addr_i = 32'h0000_0500;
      end
      #3;
      chk($sformatf("mc_c%0d_ctl", c), 32'(ctl_now()), (c < 4) ? 32'b011100 : 32'h0);
      next_cycle();
    end
    idle();
    #3;
    chk("mc_cnt", 32'(stall_cnt), 32'd4);
    chk("mc_back_run", 32'(ctl_now()), 32'h0);
    next_cycle();

    // Jump during FLUSH restarts the window
    do_reset();
    jump_en_i = 1; jump_addr_i = 32'h0000_0100;
    next_cycle();
    jump_addr_i = 32'h0000_0300;
    #3;
    chk("reflush_ctl", 32'(ctl_now()), 32'b100011);
    chk("reflush_addr", pc_load_addr, 32'h300);
    next_cycle();
    idle();
    #3;
    chk("reflush_tail", 32'(ctl_now()), 32'b000010);
    next_cycle();
    #3;
    chk("reflush_done", 32'(ctl_now()), 32'h0);
    next_cycle();

    // Halt for 20 cycles: counter saturates, holds clear as soon as the request drops
    do_reset();
    halt_req_i = 1;
    for (int c = 0; c < 20; c++) next_cycle();
    #3;
    chk("sat_hold", 32'(ctl_now()), 32'b011100);
    chk("sat_cnt", 32'(stall_cnt), 32'd15);
    next_cycle();
    halt_req_i = 0;
    #3;
    chk("halt_drop_ctl", 32'(ctl_now()), 32'h0);
    chk("halt_drop_cnt", 32'(stall_cnt), 32'd15);
    next_cycle();

    // Reset in the middle of a multi-cycle wait abandons it
    mc_start_i = 1;
    next_cycle();
    mc_start_i = 0;
    #1;
    rst = 0;
    #1;
    chk("mcrst_ctl", 32'(ctl_now()), 32'h0);
    chk("mcrst_cnt", 32'(stall_cnt), 32'h0);
    next_cycle();
    rst = 1;
    #3;
    chk("mcrst_run", 32'(ctl_now()), 32'h0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
